// File: rtl/arithm2_sched.sv
// arithm2_sched: issue controller and result FIFO for the arithm2 datapath.
// Operand sets are launched through dp_* registers. A token line rides
// alongside the datapath pipeline, and every tagged result is captured into
// a circular FIFO. Admission is credit based: results already in flight
// always have a FIFO slot waiting, so the datapath never needs to stall.

module arithm2_sched #(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 16,
    parameter int YW      = 37
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [17:0]              in_a,
    input  logic [7:0]               in_b,
    input  logic [11:0]              in_c,
    input  logic [7:0]               in_d,
    input  logic [13:0]              in_e,
    input  logic [18:0]              in_f,
    output logic                     dp_ce,
    output logic [17:0]              dp_a,
    output logic [7:0]               dp_b,
    output logic [11:0]              dp_c,
    output logic [7:0]               dp_d,
    output logic [13:0]              dp_e,
    output logic [18:0]              dp_f,
    input  logic [YW-1:0]            dp_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [YW-1:0]            out_y,
    output logic [$clog2(DEPTH):0]   inflight,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   ONE_W   = (AW+1)'(1);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

    // tok_r[0] travels with the operand registers and tok_r[k] with datapath
    // stage k, so tok_r[LATENCY] is high exactly when dp_y carries a result.
    logic [LATENCY:0] tok_r;
    logic             rst_n_q_r;
    logic             dp_ce_r;
    logic [AW:0]      inflight_r;
    logic [AW:0]      count_r;
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [YW-1:0]    mem_r [DEPTH];

    logic             acc_s;
    logic             wr_s;
    logic             rd_s;
    logic [AW+1:0]    credit_s;

    // Handshake, credit check and FIFO strobes from registered state only.
    always_comb begin
        credit_s  = {1'b0, inflight_r} + {1'b0, count_r};
        in_ready  = rst_n_q_r & (credit_s < DEPTH_W);
        acc_s     = in_valid & in_ready;
        wr_s      = tok_r[LATENCY];
        out_valid = (count_r != {(AW+1){1'b0}});
        rd_s      = out_valid & out_ready;
    end

    // Reset tracking, datapath enable, operand launch and token line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rst_n_q_r <= 1'b0;
            dp_ce_r   <= 1'b0;
            tok_r     <= '0;
            dp_a      <= 18'd0;
            dp_b      <= 8'd0;
            dp_c      <= 12'd0;
            dp_d      <= 8'd0;
            dp_e      <= 14'd0;
            dp_f      <= 19'd0;
        end else begin
            rst_n_q_r <= 1'b1;
            dp_ce_r   <= 1'b1;
            tok_r     <= {tok_r[LATENCY-1:0], acc_s};
            if (acc_s) begin
                dp_a <= in_a;
                dp_b <= in_b;
                dp_c <= in_c;
                dp_d <= in_d;
                dp_e <= in_e;
                dp_f <= in_f;
            end
        end
    end

    // In-flight result counter: up on accept, down on FIFO write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight_r <= {(AW+1){1'b0}};
        end else begin
            case ({acc_s, wr_s})
                2'b10:   inflight_r <= inflight_r + ONE_W;
                2'b01:   inflight_r <= inflight_r - ONE_W;
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // FIFO occupancy and wrapping pointers; no bypass from write to head.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r  <= {(AW+1){1'b0}};
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            case ({wr_s, rd_s})
                2'b10:   count_r <= count_r + ONE_W;
                2'b01:   count_r <= count_r - ONE_W;
                default: count_r <= count_r;
            endcase
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_W;
            end
            if (rd_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_W;
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (rst_n && wr_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= dp_y;
        end
    end

    assign out_y      = mem_r[rd_ptr_r[AW-1:0]];
    assign dp_ce      = dp_ce_r;
    assign inflight   = inflight_r;
    assign fifo_count = count_r;

    arithm2_sched_chk #(
        .DEPTH (DEPTH)
    ) u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr       (wr_s),
        .count    (count_r),
        .inflight (inflight_r),
        .wr_ptr   (wr_ptr_r),
        .rd_ptr   (rd_ptr_r)
    );

endmodule

// Invariant checks for the scheduler's FIFO and credit bookkeeping.
module arithm2_sched_chk #(
    parameter int DEPTH = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    input logic                   wr,
    input logic [$clog2(DEPTH):0] count,
    input logic [$clog2(DEPTH):0] inflight,
    input logic [$clog2(DEPTH):0] wr_ptr,
    input logic [$clog2(DEPTH):0] rd_ptr
);
    localparam int AW = $clog2(DEPTH);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr && (count == (AW+1)'(DEPTH))));

    a_credit: assert property (@(posedge clk) disable iff (!rst_n)
        (({1'b0, inflight} + {1'b0, count}) <= (AW+2)'(DEPTH)));

    a_ptr_count: assert property (@(posedge clk) disable iff (!rst_n)
        ((wr_ptr - rd_ptr) == count));
endmodule

// File: tb/tb_arithm2_sched.sv
// Scoreboard bench for arithm2_sched with a behavioural arithm2 datapath.
module tb_arithm2_sched;
    localparam int LAT = 10;
    localparam int DEP = 16;
    localparam int YW  = 37;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_ready, dp_ce, out_valid, out_ready;
    logic [17:0]   in_a, dp_a;
    logic [7:0]    in_b, dp_b, in_d, dp_d;
    logic [11:0]   in_c, dp_c;
    logic [13:0]   in_e, dp_e;
    logic [18:0]   in_f, dp_f;
    logic [YW-1:0] dp_y, out_y;
    logic [4:0]    inflight, fifo_count;

    int errors = 0, checks = 0, cyc = 0;
    int acc_cnt = 0, pop_cnt = 0, gap_cnt = 0, last_pop_cyc = 0, last_acc_cyc = 0, stall_cnt = 0;
    logic [YW-1:0] exp_q[$];
    logic [YW-1:0] cur_exp;
    logic [YW-1:0] pipe [LAT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    arithm2_sched #(.LATENCY(LAT), .DEPTH(DEP), .YW(YW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_e(in_e), .in_f(in_f),
        .dp_ce(dp_ce), .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_d(dp_d), .dp_e(dp_e), .dp_f(dp_f),
        .dp_y(dp_y), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .inflight(inflight), .fifo_count(fifo_count)
    );

    function automatic logic [36:0] ref_y(input logic [17:0] a, input logic [7:0] b,
                                          input logic [11:0] c, input logic [7:0] d,
                                          input logic [13:0] e, input logic [18:0] f);
        logic [36:0] t1, t2, t3;
        t1 = ({19'd0, a} + ({29'd0, b} << 5)) * {25'd0, c};
        t2 = ({29'd0, d} << 3) + {23'd0, e};
        t3 = ({23'd0, e} << 4) + {18'd0, f};
        return t1 + ((t2 * t3) << 1);
    endfunction

    // Behavioural datapath: LAT stages, all enabled by dp_ce.
    always @(posedge clk) begin
        if (dp_ce) begin
            pipe[0] <= ref_y(dp_a, dp_b, dp_c, dp_d, dp_e, dp_f);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign dp_y = pipe[LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: push on accept, pop and compare on output.
    initial begin
        logic [YW-1:0] e_v;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
            end else begin
                if (in_valid && in_ready) begin
                    exp_q.push_back(cur_exp);
                    acc_cnt++;
                    last_acc_cyc = cyc;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_empty: got out_y=%0d, expected no output", out_y);
                    end else begin
                        e_v = exp_q.pop_front();
                        chk("sb_out_y", 64'(out_y), 64'(e_v));
                    end
                    if (pop_cnt > 0 && cyc != last_pop_cyc + 1) gap_cnt++;
                    pop_cnt++;
                    last_pop_cyc = cyc;
                end
                chk("credit_bound", 64'(int'(inflight) + int'(fifo_count) <= DEP), 64'd1);
            end
        end
    end

    task automatic send(input logic [17:0] a, input logic [7:0] b, input logic [11:0] c,
                        input logic [7:0] d, input logic [13:0] e, input logic [18:0] f,
                        input logic [36:0] ex);
        bit ok;
        ok = 1'b0;
        in_a = a; in_b = b; in_c = c; in_d = d; in_e = e; in_f = f;
        cur_exp = ex;
        in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            if (i == 0) stall_cnt++;
            step();
        end
        if (ok) step();
        else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for 64 cycles, expected 1");
        end
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [17:0] a; logic [7:0] b; logic [11:0] c; logic [7:0] d; logic [13:0] e; logic [18:0] f;
        a = 18'($urandom); b = 8'($urandom); c = 12'($urandom);
        d = 8'($urandom); e = 14'($urandom); f = 19'($urandom);
        send(a, b, c, d, e, f, ref_y(a, b, c, d, e, f));
    endtask

    task automatic wait_empty(input string name, input int bound);
        bit done;
        done = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && inflight == 5'd0 && fifo_count == 5'd0) begin
                done = 1'b1;
                break;
            end
        end
        chk(name, 64'(done), 64'd1);
        step();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_acc, lat;
        bit found;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = 18'd0; in_b = 8'd0; in_c = 12'd0; in_d = 8'd0; in_e = 14'd0; in_f = 19'd0;
        cur_exp = 37'd0;

        // Reset state
        repeat (3) step();
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_dp_ce", 64'(dp_ce), 64'd0);
        chk("reset_inflight", 64'(inflight), 64'd0);
        chk("reset_fifo_count", 64'(fifo_count), 64'd0);
        chk("reset_dp_a", 64'(dp_a), 64'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_before_sample", 64'(in_ready), 64'd0);
        step();
        @(negedge clk);
        chk("ready_after_release", 64'(in_ready), 64'd1);
        chk("dp_ce_after_release", 64'(dp_ce), 64'd1);
        step();

        // Single set: latency and value
        out_ready = 1'b1;
        send(18'd1, 8'd1, 12'd2, 8'd1, 14'd1, 19'd1, 37'd372);
        t_acc = last_acc_cyc;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1'b1;
                break;
            end
        end
        lat = found ? cyc - t_acc : -1;
        chk("single_latency", 64'(lat), 64'd12);
        chk("single_out_y", 64'(out_y), 64'd372);
        step();
        @(negedge clk);
        chk("single_inflight_zero", 64'(inflight), 64'd0);
        chk("single_fifo_empty", 64'(fifo_count), 64'd0);
        step();

        // Directed vectors back-to-back
        send(18'd0, 8'd0, 12'd0, 8'd0, 14'd0, 19'd0, 37'd0);
        send(18'd3, 8'd0, 12'd5, 8'd0, 14'd2, 19'd7, 37'd171);
        send(18'd0, 8'd1, 12'd1, 8'd1, 14'd0, 19'd0, 37'd32);
        send(18'd262143, 8'd255, 12'd4095, 8'd255, 14'd16383, 19'd524287, 37'd30083137875);
        send(18'd5, 8'd2, 12'd3, 8'd0, 14'd1, 19'd0, 37'd239);
        wait_empty("drain_directed", 60);

        // 100 back-to-back sets, out_ready held high
        pop_cnt = 0; gap_cnt = 0; stall_cnt = 0;
        for (int i = 0; i < 100; i++) send_rand();
        wait_empty("drain_stream", 60);
        chk("stream_stalls", 64'(stall_cnt), 64'd0);
        chk("stream_outputs", 64'(pop_cnt), 64'd100);
        chk("stream_gaps", 64'(gap_cnt), 64'd0);

        // Fill with out_ready low
        out_ready = 1'b0;
        acc_cnt = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            in_a = 18'($urandom); in_b = 8'($urandom); in_c = 12'($urandom);
            in_d = 8'($urandom); in_e = 14'($urandom); in_f = 19'($urandom);
            cur_exp = ref_y(in_a, in_b, in_c, in_d, in_e, in_f);
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_accepted", 64'(acc_cnt), 64'd16);
        chk("full_fifo_count", 64'(fifo_count), 64'd16);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_inflight", 64'(inflight), 64'd0);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("ready_at_first_read", 64'(in_ready), 64'd0);
        step();
        @(negedge clk);
        chk("ready_after_first_read", 64'(in_ready), 64'd1);
        step();
        wait_empty("drain_full", 40);

        // Random valid/ready
        pop_cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_a = 18'($urandom); in_b = 8'($urandom); in_c = 12'($urandom);
            in_d = 8'($urandom); in_e = 14'($urandom); in_f = 19'($urandom);
            cur_exp = ref_y(in_a, in_b, in_c, in_d, in_e, in_f);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_empty("drain_random", 100);
        chk("random_wraps", 64'(pop_cnt > 160), 64'd1);

        // Reset with work in flight and in the FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_rand();
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (fifo_count == 5'd3) begin
                found = 1'b1;
                break;
            end
        end
        chk("pre_reset_fill", 64'(found), 64'd1);
        step();
        for (int i = 0; i < 5; i++) send_rand();
        @(negedge clk);
        chk("pre_reset_inflight", 64'(inflight), 64'd5);
        chk("pre_reset_fifo", 64'(fifo_count), 64'd3);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_out_valid", 64'(out_valid), 64'd0);
        chk("post_reset_inflight", 64'(inflight), 64'd0);
        chk("post_reset_fifo", 64'(fifo_count), 64'd0);
        chk("post_reset_dp_ce", 64'(dp_ce), 64'd0);
        chk("post_reset_in_ready", 64'(in_ready), 64'd0);
        step();
        out_ready = 1'b1;
        pop_cnt = 0;
        repeat (20) step();
        chk("no_stale_outputs", 64'(pop_cnt), 64'd0);
        send(18'd5, 8'd2, 12'd3, 8'd0, 14'd1, 19'd0, 37'd239);
        wait_empty("drain_after_reset", 40);
        chk("fresh_output_count", 64'(pop_cnt), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
